// File: rtl/ecc_encryption_pkg.sv
// Shared constants, FSM state encoding and a modular helper for the ECC
// encryption block. The decryption stage uses the same modulus.
package ecc_encryption_pkg;

  localparam int WIDTH = 256;
  localparam int MSG_W = 128;
  localparam int CNT_W = $clog2(WIDTH);

  // secp256k1 field prime
  localparam logic [WIDTH-1:0] P_MOD =
    256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL1 = 2'd1,
    ST_MUL2 = 2'd2,
    ST_FIN  = 2'd3
  } state_t;

  // Bring a value below 2P into [0, P) with at most one subtraction.
  function automatic logic [WIDTH-1:0] reduce_once(input logic [WIDTH:0] x);
    logic [WIDTH:0] diff;
    diff = x - {1'b0, P_MOD};
    return (x >= {1'b0, P_MOD}) ? diff[WIDTH-1:0] : x[WIDTH-1:0];
  endfunction

endpackage

// File: rtl/ecc_encryption_if.sv
// Request/response bundle for the ECC encryption block: the producer drives
// start and the operands, the block returns the ciphertext and status.
interface ecc_encryption_if;
  import ecc_encryption_pkg::*;

  logic             start;
  logic [MSG_W-1:0] M;
  logic [WIDTH-1:0] k;
  logic [WIDTH-1:0] G;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] C1;
  logic [WIDTH-1:0] C2;
  logic             busy;
  logic             done;

  modport master (
    output start, M, k, G, Q,
    input  C1, C2, busy, done
  );

  modport slave (
    input  start, M, k, G, Q,
    output C1, C2, busy, done
  );

endinterface

// File: rtl/ecc_encryption_mult.sv
// Sequential modular multiplier: right-to-left double-and-add, one scalar
// bit per cycle. result = a*b mod P_MOD, valid while done is high.
module mod_mult_seq
  import ecc_encryption_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
  logic             load;

  // Sums carry one extra bit so c+b and 2b never overflow before reduction.
  logic [WIDTH:0] acc_sum;
  logic [WIDTH:0] dbl;

  assign load    = start && !busy_q;
  assign acc_sum = {1'b0, c_q} + {1'b0, b_q};
  assign dbl     = {b_q, 1'b0};

  // Control: busy across WIDTH iteration edges, then a one-cycle done pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (load) begin
        busy_q <= 1'b1;
        cnt_q  <= '0;
      end else if (busy_q) begin
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Datapath: load operands, then one double-and-add step per busy cycle.
  always_ff @(posedge clk) begin
    // NOTE: datapath registers are not reset; they are always loaded before
    // use and are only observed qualified by done.
    if (load) begin
      a_q <= a;
      b_q <= reduce_once({1'b0, b});
      c_q <= '0;
    end else if (busy_q) begin
      if (a_q[0]) c_q <= reduce_once(acc_sum);
      b_q <= reduce_once(dbl);
      a_q <= a_q >> 1;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = c_q;

endmodule

// File: rtl/ecc_encryption.sv
// ECC encryption: C1 = k*G mod P, S = k*Q mod P, C2 = {0, M ^ S[MSG_W-1:0]}.
// One shared multiplier runs twice back to back under a four-state FSM.
module ecc_encryption
  import ecc_encryption_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  ecc_encryption_if.slave  bus
);

  state_t           state_q, state_d;
  logic             accept;
  logic             mult_start;
  logic [WIDTH-1:0] mult_b;
  logic             mult_busy;
  logic             mult_done;
  logic [WIDTH-1:0] mult_result;

  logic [MSG_W-1:0] m_q;
  logic [WIDTH-1:0] k_q;
  logic [WIDTH-1:0] g_q;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] c1_hold;
  logic [WIDTH-1:0] c1_q;
  logic [WIDTH-1:0] c2_q;

  mod_mult_seq u_mult (
    .clk    (clk),
    .rst    (rst),
    .start  (mult_start),
    .a      (k_q),
    .b      (mult_b),
    .busy   (mult_busy),
    .done   (mult_done),
    .result (mult_result)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state, accept and multiplier launch; the multiplier is started on
  // the first cycle of each MUL state, when it is neither busy nor done.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned, which would infer a latch.
    state_d    = state_q;
    accept     = 1'b0;
    mult_start = 1'b0;
    mult_b     = g_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_MUL1;
        end
      end
      ST_MUL1: begin
        mult_b     = g_q;
        mult_start = !mult_busy && !mult_done;
        if (mult_done) state_d = ST_MUL2;
      end
      ST_MUL2: begin
        mult_b     = q_q;
        mult_start = !mult_busy && !mult_done;
        if (mult_done) state_d = ST_FIN;
      end
      ST_FIN: begin
        // busy is already low here, so a new request is taken directly.
        if (bus.start) begin
          accept  = 1'b1;
          state_d = ST_MUL1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latches; inputs are free to change after the accept edge.
  always_ff @(posedge clk) begin
    if (accept) begin
      m_q <= bus.M;
      k_q <= bus.k;
      g_q <= bus.G;
      q_q <= bus.Q;
    end
  end

  // Results: C1 is parked internally, and both outputs update together on
  // the edge into FIN so the old ciphertext stays visible while busy.
  always_ff @(posedge clk) begin
    if (rst) begin
      c1_q <= '0;
      c2_q <= '0;
    end else if (mult_done) begin
      if (state_q == ST_MUL1) begin
        c1_hold <= mult_result;
      end else if (state_q == ST_MUL2) begin
        c1_q <= c1_hold;
        c2_q <= {{(WIDTH - MSG_W){1'b0}}, m_q ^ mult_result[MSG_W-1:0]};
      end
    end
  end

  assign bus.C1   = c1_q;
  assign bus.C2   = c2_q;
  assign bus.busy = (state_q == ST_MUL1) || (state_q == ST_MUL2);
  assign bus.done = (state_q == ST_FIN);

endmodule

// File: tb/tb_ecc_encryption.sv
// Directed bench for ecc_encryption: hand-computed ciphertexts, fixed
// latency, start-while-busy, back-to-back accept and mid-operation reset.
module tb_ecc_encryption;
  import ecc_encryption_pkg::*;

  localparam int LAT   = 517;
  localparam int LIMIT = 1000;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  ecc_encryption_if bus ();

  ecc_encryption dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic [255:0] kv, input logic [255:0] gv,
                       input logic [255:0] qv, input logic [127:0] mv);
    bus.k = kv;
    bus.G = gv;
    bus.Q = qv;
    bus.M = mv;
  endtask

  // Present a request on a falling edge, step past the accept edge, and
  // optionally keep start asserted afterwards.
  task automatic start_op(input logic [255:0] kv, input logic [255:0] gv,
                          input logic [255:0] qv, input logic [127:0] mv,
                          input bit hold);
    @(negedge clk);
    apply(kv, gv, qv, mv);
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) bus.start = 1'b0;
  endtask

  // Count cycles since accept until done is seen, bounded by LIMIT.
  task automatic wait_done(input int lat0, output int lat);
    lat = lat0;
    while (!bus.done && lat < LIMIT) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  initial begin
    int lat;
    int seen;
    logic [255:0] d_c1;
    logic [127:0] m4;

    bus.start = 1'b0;
    apply('0, '0, '0, '0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_c1", bus.C1, '0);
    check("rst_c2", bus.C2, '0);
    check("rst_busy", 256'(bus.busy), 256'd0);
    check("rst_done", 256'(bus.done), 256'd0);
    rst = 1'b0;

    // 1: trivial scalar
    start_op(256'd1, 256'd5, 256'd7, 128'hA5, 1'b0);
    check("t1_busy", 256'(bus.busy), 256'd1);
    wait_done(1, lat);
    check("t1_latency", 256'(lat), 256'(LAT));
    check("t1_c1", bus.C1, 256'd5);
    check("t1_c2", bus.C2, 256'hA2);
    check("t1_c2_upper", 256'(bus.C2[255:128]), 256'd0);
    @(posedge clk);
    #1;
    check("t1_done_pulse", 256'(bus.done), 256'd0);

    // 2: wrap-around at P-1
    start_op(256'd2, P_MOD - 256'd1, 256'd1, 128'h0, 1'b0);
    wait_done(1, lat);
    check("t2_latency", 256'(lat), 256'(LAT));
    check("t2_c1", bus.C1, P_MOD - 256'd2);
    check("t2_c2", bus.C2, 256'd2);

    // 3: base value above P is reduced on load
    start_op(256'd1, {256{1'b1}}, 256'd0, 128'hFF, 1'b0);
    wait_done(1, lat);
    check("t3_c1", bus.C1, 256'h1_0000_03D0);
    check("t3_c2", bus.C2, 256'hFF);

    // 4: round trip with d=3, Q=d*G
    m4 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;
    start_op(256'd4, 256'd9, 256'd27, m4, 1'b0);
    wait_done(1, lat);
    check("t4_c1", bus.C1, 256'd36);
    check("t4_c2", bus.C2, {128'h0, 128'h0123_4567_89AB_CDEF_0011_2233_4455_661B});
    d_c1 = 256'd3 * bus.C1;
    check("t4_decrypt", 256'(bus.C2[127:0] ^ d_c1[127:0]), 256'(m4));

    // 5: start held through the op with inputs changing mid-op, then a
    // second op accepted in the done cycle
    start_op(256'd3, 256'd5, 256'd7, 128'h10, 1'b1);
    repeat (99) begin
      @(posedge clk);
      #1;
    end
    check("t5_busy_mid", 256'(bus.busy), 256'd1);
    apply(256'd2, 256'd10, 256'd3, 128'h1);
    wait_done(100, lat);
    check("t5_latency_a", 256'(lat), 256'(LAT));
    check("t5_c1_a", bus.C1, 256'd15);
    check("t5_c2_a", bus.C2, 256'h05);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("t5_busy_b", 256'(bus.busy), 256'd1);
    check("t5_c1_held", bus.C1, 256'd15);
    wait_done(1, lat);
    check("t5_latency_b", 256'(lat), 256'(LAT));
    check("t5_c1_b", bus.C1, 256'd20);
    check("t5_c2_b", bus.C2, 256'h07);

    // 6: reset in the middle of an op
    start_op(256'd1, 256'd5, 256'd7, 128'hA5, 1'b0);
    repeat (199) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("t6_busy", 256'(bus.busy), 256'd0);
    check("t6_c1", bus.C1, '0);
    check("t6_c2", bus.C2, '0);
    seen = 0;
    repeat (600) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    check("t6_no_done", 256'(seen), 256'd0);
    start_op(256'd4, 256'd9, 256'd27, 128'h0, 1'b0);
    wait_done(1, lat);
    check("t6_latency", 256'(lat), 256'(LAT));
    check("t6_c1", bus.C1, 256'd36);
    check("t6_c2", bus.C2, 256'h6C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
